// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add multiplier: signed or unsigned, one multiplier bit per clock.
// done pulses M edges after start is sampled; y is held between results.
module seq_mult #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [N+M-1:0]   y
);

  localparam int W  = N + M;
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           load, last;
  logic [W-1:0]   a_sh;
  logic [M-1:0]   b_sh;
  logic           neg;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc;
  logic [W-1:0]   sum;
  logic [N-1:0]   a_abs;
  logic [M-1:0]   b_abs;

  // Magnitudes fit in N/M unsigned bits even for the most negative operand.
  assign a_abs = (sgn && a[N-1]) ? -a : a;
  assign b_abs = (sgn && b[M-1]) ? -b : b;
  assign sum   = acc + (b_sh[0] ? a_sh : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(M - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a_sh carries |a| << i and b_sh exposes multiplier bit i at its LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      neg  <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      y    <= '0;
    end else if (load) begin
      a_sh <= W'(a_abs);
      b_sh <= b_abs;
      neg  <= sgn & (a[N-1] ^ b[M-1]);
      cnt  <= '0;
      acc  <= '0;
    end else if (busy) begin
      acc  <= sum;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (last) begin
        y <= neg ? -sum : sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: a 4x4 and an 8x4 instance, table vectors, corner sequences and a random sweep,
// with a scoreboard checking every done pulse for value and latency.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  y4;
  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [3:0]  b8 = '0;
  logic        busy8, done8;
  logic [11:0] y8;

  seq_mult #(.N(4), .M(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .y(y4)
  );

  seq_mult #(.N(8), .M(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] y;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          w;
    bit          sg;
    logic [7:0]  a;
    logic [3:0]  b;
    logic [11:0] y;
  } vec_t;

  exp_t        q4[$];
  exp_t        q8[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [11:0] last4 = '0;
  logic [11:0] last8 = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done4: got done with no pending op (t=%0t)", $time);
      end else begin
        e = q4.pop_front();
        check("y4", {24'b0, y4}, {20'b0, e.y});
        check("latency4", cyc, e.cyc);
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done8: got done with no pending op (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        check("y8", {20'b0, y8}, {20'b0, e.y});
        check("latency8", cyc, e.cyc);
      end
    end
  end

  function automatic logic bsy(input bit w);
    return w ? busy8 : busy4;
  endfunction

  function automatic logic dn(input bit w);
    return w ? done8 : done4;
  endfunction

  function automatic logic [11:0] yv(input bit w);
    return w ? y8 : {4'b0, y4};
  endfunction

  function automatic logic [11:0] ref_mul(input bit sg, input logic [7:0] av, input int na,
                                          input logic [3:0] bv);
    int x, z, p;
    x = int'(av);
    if (sg && av[na-1]) x -= (1 << na);
    z = int'(bv);
    if (sg && bv[3]) z -= 16;
    p = x * z;
    return 12'(p);
  endfunction

  // Called at a negedge; the next posedge samples start.
  task automatic issue(input bit w, input bit sg, input logic [7:0] av, input logic [3:0] bv,
                       input logic [11:0] ev);
    exp_t e;
    e.cyc = cyc + 1 + 4;
    if (w) begin
      sgn8 = sg; a8 = av; b8 = bv; start8 = 1'b1;
      e.y = ev;
      q8.push_back(e);
    end else begin
      sgn4 = sg; a4 = av[3:0]; b4 = bv; start4 = 1'b1;
      e.y = {4'b0, ev[7:0]};
      q4.push_back(e);
    end
  endtask

  task automatic wait_done(input bit w, output int nb);
    int guard;
    nb = 0;
    guard = 0;
    while (dn(w) !== 1'b1 && guard < 30) begin
      if (bsy(w) === 1'b1) nb++;
      @(negedge clk);
      guard++;
    end
    if (dn(w) !== 1'b1) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a pulse", guard);
    end
  endtask

  task automatic do_op(input bit w, input bit sg, input logic [7:0] av, input logic [3:0] bv,
                       input logic [11:0] ev);
    int nb;
    @(negedge clk);
    issue(w, sg, av, bv, ev);
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    check("busy_after_start", {31'b0, bsy(w)}, 32'd1);
    check("y_hold_in_run", {20'b0, yv(w)}, {20'b0, (w ? last8 : last4)});
    wait_done(w, nb);
    check("busy_cycles", nb, 32'd4);
    check("busy_low_in_done", {31'b0, bsy(w)}, 32'd0);
    @(negedge clk);
    check("idle_after_done", {30'b0, bsy(w), dn(w)}, 32'd0);
    check("y_hold_in_idle", {20'b0, yv(w)}, {20'b0, (w ? ev : {4'b0, ev[7:0]})});
    if (w) last8 = ev; else last4 = {4'b0, ev[7:0]};
  endtask

  vec_t tbl[18];

  initial begin
    int          nb;
    logic [7:0]  ra;
    logic [3:0]  rb;
    bit          rs;

    tbl = '{
      '{0, 0, 8'h0F, 4'hF, 12'h0E1}, '{0, 1, 8'h08, 4'h8, 12'h040},
      '{0, 1, 8'h08, 4'h7, 12'h0C8}, '{0, 1, 8'h0F, 4'h0, 12'h000},
      '{0, 1, 8'h0F, 4'hF, 12'h001}, '{0, 0, 8'h09, 4'h3, 12'h01B},
      '{0, 1, 8'h07, 4'h7, 12'h031}, '{0, 1, 8'h07, 4'h8, 12'h0C8},
      '{0, 1, 8'h0F, 4'h1, 12'h0FF}, '{0, 0, 8'h00, 4'hF, 12'h000},
      '{0, 1, 8'h00, 4'h8, 12'h000}, '{0, 1, 8'h08, 4'hF, 12'h008},
      '{1, 1, 8'h80, 4'h8, 12'h400}, '{1, 0, 8'hFF, 4'hF, 12'hEF1},
      '{1, 1, 8'hFF, 4'h1, 12'hFFF}, '{1, 1, 8'h7F, 4'h7, 12'h379},
      '{1, 1, 8'h80, 4'h7, 12'hC80}, '{1, 0, 8'h80, 4'h8, 12'h400}
    };

    #1;
    check("rst_busy4", {31'b0, busy4}, 32'd0);
    check("rst_done4", {31'b0, done4}, 32'd0);
    check("rst_y4", {24'b0, y4}, 32'd0);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_y8", {20'b0, y8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_without_start", {31'b0, busy4}, 32'd0);

    foreach (tbl[i]) do_op(tbl[i].w, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].y);

    // Back-to-back: start held through the DONE cycle with new operands.
    @(negedge clk);
    issue(0, 0, 8'd2, 4'd6, 12'd12);
    @(negedge clk);
    start4 = 1'b0;
    wait_done(0, nb);
    check("b2b_first_busy", nb, 32'd4);
    issue(0, 0, 8'd3, 4'd5, 12'd15);
    @(negedge clk);
    start4 = 1'b0;
    check("b2b_busy_gap_one_cycle", {31'b0, busy4}, 32'd1);
    wait_done(0, nb);
    check("b2b_second_busy", nb, 32'd4);
    @(negedge clk);
    last4 = 12'd15;

    // start pulsed and operands changed mid-RUN must not disturb the op.
    @(negedge clk);
    issue(0, 0, 8'd6, 4'd7, 12'd42);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; sgn4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done(0, nb);
    check("ignore_start_busy", nb, 32'd2);
    @(negedge clk);
    check("ignore_start_idle", {31'b0, busy4}, 32'd0);
    last4 = 12'd42;

    // Asynchronous reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    sgn4 = 1'b0; a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_y", {24'b0, y4}, 32'd0);
    check("abort_busy", {31'b0, busy4}, 32'd0);
    check("abort_done", {31'b0, done4}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stay_idle_after_reset", {31'b0, busy4}, 32'd0);
    end
    last4 = '0;
    last8 = '0;
    do_op(0, 0, 8'h0F, 4'hF, 12'h0E1);

    for (int i = 0; i < 24; i++) begin
      rs = i[0];
      ra = 8'($urandom);
      rb = 4'($urandom);
      do_op(1, rs, ra, rb, ref_mul(rs, ra, 8, rb));
    end
    for (int i = 0; i < 10; i++) begin
      rs = i[0];
      ra = {4'b0, 4'($urandom)};
      rb = 4'($urandom);
      do_op(0, rs, ra, rb, ref_mul(rs, ra, 4, rb) & 12'h0FF);
    end

    repeat (3) @(negedge clk);
    check("queue4_empty", q4.size(), 32'd0);
    check("queue8_empty", q8.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, required finish before %0t", $time);
    $fatal(1);
  end

endmodule
